rpn_engine: RTL and testbench

RPN_ENGINE -- requirements
Module: rpn_engine

---
 rtl/rpn_pkg.sv | 40 ++++
 rtl/rpn_alu.sv | 25 ++
 rtl/rpn_engine.sv | 199 +++++++++++++++++++
 tb/tb_rpn_engine.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// Shared types and constants for the RPN command engine.
// Define RPN_MUL_EN to build the multiplier; otherwise MUL is rejected as illegal.
package rpn_pkg;

    localparam int STACK_DEPTH = 64;
    localparam int DATA_W      = 32;
    localparam int COUNT_W     = $clog2(STACK_DEPTH);

`ifdef RPN_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_MUL  = 3'd4,
        OP_DUP  = 3'd5,
        OP_DROP = 3'd6,
        OP_SWAP = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PUSH     = 3'd1,
        POP      = 3'd2,
        WR       = 3'd3,
        SWP_PUSH = 3'd4,
        SWP_WR   = 3'd5
    } state_e;

    localparam logic [1:0] FAULT_NONE      = 2'd0;
    localparam logic [1:0] FAULT_UNDERFLOW = 2'd1;
    localparam logic [1:0] FAULT_OVERFLOW  = 2'd2;
    localparam logic [1:0] FAULT_ILLEGAL   = 2'd3;

endpackage

// File: rtl/rpn_alu.sv
// Combinational arithmetic for ADD/SUB/MUL on the two sampled operands.
// The multiplier exists only when RPN_MUL_EN is defined.
module rpn_alu
    import rpn_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] next_i,
    input  logic [31:0] top_i,
    output logic [31:0] result_o
);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        result_o = '0;
        case (op_e'(op_i))
            OP_ADD:  result_o = next_i + top_i;
            OP_SUB:  result_o = next_i - top_i;
`ifdef RPN_MUL_EN
            OP_MUL:  result_o = next_i * top_i;
`endif
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/rpn_engine.sv
// RPN command sequencer: turns one accepted command into a burst of stack strobes.
// MUL support depends on RPN_MUL_EN (see rpn_pkg).
module rpn_engine
    import rpn_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_value,
    output logic        stk_push,
    output logic        stk_pop,
    output logic        stk_write,
    output logic [31:0] stk_value,
    input  logic [31:0] stk_top,
    input  logic [31:0] stk_next,
    input  logic [5:0]  stk_count,
    input  logic        stk_error,
    output logic        done,
    output logic [1:0]  fault
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [31:0] top_q, top_d;
    logic [31:0] next_q, next_d;
    logic [31:0] value_q, value_d;
    logic [1:0]  fault_q, fault_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;
    logic        push_q, push_d;
    logic        pop_q, pop_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;

    logic [31:0] alu_result;
    logic [31:0] wr_value;
    logic [1:0]  cmd_fault;
    logic        stk_full;
    logic        stk_single;

    // A count of zero is the wrapped encoding of a completely full stack.
    assign stk_full   = (stk_count == '0);
    assign stk_single = (stk_count == 6'd1);

    rpn_alu u_alu (
        .op_i     (op_q),
        .next_i   (next_q),
        .top_i    (top_q),
        .result_o (alu_result)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        top_d     = top_q;
        next_d    = next_q;
        value_d   = value_q;
        done_d    = 1'b0;
        cmd_fault = FAULT_NONE;

        case (state_q)
            IDLE: begin
                if (cmd_valid && ready_q) begin
                    op_d    = op_e'(cmd_op);
                    top_d   = stk_top;
                    next_d  = stk_next;
                    value_d = cmd_value;
                    case (op_e'(cmd_op))
                        OP_PUSH, OP_DUP: begin
                            if (stk_full) cmd_fault = FAULT_OVERFLOW;
                            else          state_d   = PUSH;
                        end
                        OP_ADD, OP_SUB, OP_SWAP: begin
                            if (stk_single) cmd_fault = FAULT_UNDERFLOW;
                            else            state_d   = POP;
                        end
                        OP_MUL: begin
                            if (!MUL_EN)         cmd_fault = FAULT_ILLEGAL;
                            else if (stk_single) cmd_fault = FAULT_UNDERFLOW;
                            else                 state_d   = POP;
                        end
                        OP_DROP: state_d = stk_single ? WR : POP;
                        default: ;
                    endcase
                    // Rejected commands and NOP complete without leaving IDLE.
                    done_d = (state_d == IDLE);
                end
            end
            PUSH: state_d = WR;
            POP: begin
                if (op_q == OP_DROP) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = WR;
                end
            end
            WR: begin
                if (op_q == OP_SWAP) begin
                    state_d = SWP_PUSH;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            SWP_PUSH: state_d = SWP_WR;
            SWP_WR: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Data for the first write of a sequence, chosen by the command in flight.
    always_comb begin
        wr_value = '0;
        case (op_d)
            OP_PUSH:                wr_value = value_d;
            OP_DUP, OP_SWAP:        wr_value = top_d;
            OP_ADD, OP_SUB, OP_MUL: wr_value = alu_result;
            default:                wr_value = '0;
        endcase
    end

    // Strobes are decoded from the next state so they appear registered in that state's cycle.
    always_comb begin
        push_d  = 1'b0;
        pop_d   = 1'b0;
        write_d = 1'b0;
        wdata_d = wdata_q;
        case (state_d)
            PUSH, SWP_PUSH: push_d = 1'b1;
            POP:            pop_d  = 1'b1;
            WR: begin
                write_d = 1'b1;
                wdata_d = wr_value;
            end
            SWP_WR: begin
                write_d = 1'b1;
                wdata_d = next_d;
            end
            default: ;
        endcase
    end

    assign ready_d = (state_d == IDLE);

    // Only the first fault is kept; command faults win over a same-cycle stack error.
    always_comb begin
        fault_d = fault_q;
        if (fault_q == FAULT_NONE) begin
            if (cmd_fault != FAULT_NONE) fault_d = cmd_fault;
            else if (stk_error)          fault_d = FAULT_OVERFLOW;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            top_q   <= '0;
            next_q  <= '0;
            value_q <= '0;
            fault_q <= FAULT_NONE;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            top_q   <= top_d;
            next_q  <= next_d;
            value_q <= value_d;
            fault_q <= fault_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            push_q  <= push_d;
            pop_q   <= pop_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
        end
    end

    assign cmd_ready = ready_q;
    assign stk_push  = push_q;
    assign stk_pop   = pop_q;
    assign stk_write = write_q;
    assign stk_value = wdata_q;
    assign done      = done_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_rpn_engine.sv
// Bench for rpn_engine: a behavioural stack answers the strobes, and a queue-based
// RPN model predicts strobe traces, stack contents and the sticky fault code.
`timescale 1ns/1ps
module tb_rpn_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_value;
    logic        stk_push, stk_pop, stk_write;
    logic [31:0] stk_value, stk_top, stk_next;
    logic [5:0]  stk_count;
    logic        stk_error;
    logic        done;
    logic [1:0]  fault;

`ifdef RPN_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    localparam int K_PUSH = 1;
    localparam int K_POP  = 2;
    localparam int K_WR   = 3;

    rpn_engine dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_value (cmd_value),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_write (stk_write),
        .stk_value (stk_value),
        .stk_top   (stk_top),
        .stk_next  (stk_next),
        .stk_count (stk_count),
        .stk_error (stk_error),
        .done      (done),
        .fault     (fault)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Environment stack: obeys the strobes, never reset by the engine reset.
    logic [31:0] mem [64];
    logic [6:0]  cnt = 7'd1;
    logic        stk_clear = 1'b0;
    logic        err_inject = 1'b0;

    always @(posedge clock) begin
        if (stk_clear) begin
            cnt    <= 7'd1;
            mem[0] <= 32'h0;
        end else if (stk_push) begin
            cnt <= cnt + 7'd1;
        end else if (stk_pop) begin
            cnt <= cnt - 7'd1;
        end else if (stk_write) begin
            mem[6'(cnt - 7'd1)] <= stk_value;
        end
    end

    always_comb begin
        stk_top   = mem[6'(cnt - 7'd1)];
        stk_next  = mem[6'(cnt - 7'd2)];
        stk_count = cnt[5:0];
        stk_error = err_inject;
    end

    // Reference model state: stack as a queue (last element is the top).
    logic [31:0] ref_q[$];
    logic [1:0]  ref_fault = 2'd0;
    int          exp_k[$];
    logic [31:0] exp_v[$];

    function automatic void set_fault(input logic [1:0] f);
        if (ref_fault == 2'd0) ref_fault = f;
    endfunction

    function automatic void expect_ev(input int k, input logic [31:0] v);
        exp_k.push_back(k);
        exp_v.push_back(v);
    endfunction

    function automatic void model(input logic [2:0] op, input logic [31:0] val);
        int n;
        logic [31:0] a, b, r;
        exp_k.delete();
        exp_v.delete();
        n = ref_q.size();
        case (op)
            3'd1, 3'd5: begin
                if (n == 64) set_fault(2'd2);
                else begin
                    r = (op == 3'd1) ? val : ref_q[n-1];
                    expect_ev(K_PUSH, 32'h0);
                    expect_ev(K_WR, r);
                    ref_q.push_back(r);
                end
            end
            3'd2, 3'd3, 3'd4: begin
                if (op == 3'd4 && !MUL_ON) set_fault(2'd3);
                else if (n == 1) set_fault(2'd1);
                else begin
                    b = ref_q.pop_back();
                    a = ref_q.pop_back();
                    r = (op == 3'd2) ? a + b : (op == 3'd3) ? a - b : a * b;
                    expect_ev(K_POP, 32'h0);
                    expect_ev(K_WR, r);
                    ref_q.push_back(r);
                end
            end
            3'd6: begin
                if (n == 1) begin
                    expect_ev(K_WR, 32'h0);
                    ref_q[0] = 32'h0;
                end else begin
                    expect_ev(K_POP, 32'h0);
                    void'(ref_q.pop_back());
                end
            end
            3'd7: begin
                if (n == 1) set_fault(2'd1);
                else begin
                    b = ref_q.pop_back();
                    a = ref_q.pop_back();
                    expect_ev(K_POP, 32'h0);
                    expect_ev(K_WR, b);
                    expect_ev(K_PUSH, 32'h0);
                    expect_ev(K_WR, a);
                    ref_q.push_back(b);
                    ref_q.push_back(a);
                end
            end
            default: ;
        endcase
    endfunction

    function automatic string fmt(input int k[$], input logic [31:0] v[$]);
        string s = "";
        foreach (k[i]) begin
            if (k[i] == K_PUSH)     s = {s, "push "};
            else if (k[i] == K_POP) s = {s, "pop "};
            else if (k[i] == K_WR)  s = {s, $sformatf("wr(%h) ", v[i])};
            else                    s = {s, "none "};
        end
        return s;
    endfunction

    task automatic check_stack(input string name);
        int n;
        bit ok;
        n = ref_q.size();
        ok = (stk_count === 6'(n)) && (stk_top === ref_q[n-1]);
        if (n >= 2 && stk_next !== ref_q[n-2]) ok = 1'b0;
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s stack: count=%0d top=%h next=%h, required count=%0d top=%h", name,
                     stk_count, stk_top, stk_next, 6'(n), ref_q[n-1]);
        end
    endtask

    // Issue one command (back-to-back if the engine is ready) and check everything it does.
    task automatic do_cmd(input logic [2:0] op, input logic [31:0] val);
        int          obs_k[$];
        logic [31:0] obs_v[$];
        int          wait_c;
        bit          got_done, seq_ok, trace_ok;
        model(op, val);
        wait_c = 0;
        while (!cmd_ready && wait_c < 20) begin
            @(negedge clock);
            wait_c++;
        end
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_wait op=%0d: cmd_ready=%b, required 1", op, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_value = val;
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_value = $urandom;
        got_done  = 1'b0;
        seq_ok    = 1'b1;
        for (int cyc = 1; cyc <= 8 && !got_done; cyc++) begin
            if (done) begin
                got_done = 1'b1;
                if ((stk_push | stk_pop | stk_write) || !cmd_ready) seq_ok = 1'b0;
            end else begin
                if ($countones({stk_push, stk_pop, stk_write}) != 1 || cmd_ready) seq_ok = 1'b0;
                obs_k.push_back(stk_push ? K_PUSH : stk_pop ? K_POP : stk_write ? K_WR : 0);
                obs_v.push_back(stk_write ? stk_value : 32'h0);
                @(negedge clock);
            end
        end
        n_vec++;
        if (got_done !== 1'b1) begin
            n_err++;
            $display("FAIL done op=%0d: no done pulse within 8 cycles, required one", op);
        end
        n_vec++;
        if (seq_ok !== 1'b1) begin
            n_err++;
            $display("FAIL handshake op=%0d: strobe/ready pattern broken, required one strobe per busy cycle and ready with done", op);
        end
        trace_ok = (obs_k.size() == exp_k.size());
        for (int i = 0; i < obs_k.size() && i < exp_k.size(); i++)
            if (obs_k[i] != exp_k[i] || obs_v[i] !== exp_v[i]) trace_ok = 1'b0;
        n_vec++;
        if (!trace_ok) begin
            n_err++;
            $display("FAIL trace op=%0d: got [%s], required [%s]", op, fmt(obs_k, obs_v), fmt(exp_k, exp_v));
        end
        n_vec++;
        if (fault !== ref_fault) begin
            n_err++;
            $display("FAIL fault op=%0d: fault=%0d, required %0d", op, fault, ref_fault);
        end
        check_stack($sformatf("op%0d", op));
    endtask

    task automatic fresh_stack();
        stk_clear = 1'b1;
        @(negedge clock);
        stk_clear = 1'b0;
        ref_q.delete();
        ref_q.push_back(32'h0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        ref_fault = 2'd0;
    endtask

    task automatic expect_const(input string name, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stk_clear = 1'b1;
        repeat (2) @(negedge clock);
        stk_clear = 1'b0;
        expect_const("reset_outputs", {26'h0, cmd_ready, stk_push, stk_pop, stk_write, done, 1'b0},
                     32'h0);
        expect_const("reset_fault", 32'(fault), 32'h0);
        reset = 1'b0;
        #1;
        expect_const("ready_before_edge", 32'(cmd_ready), 32'h0);
        @(negedge clock);
        expect_const("ready_after_edge", 32'(cmd_ready), 32'h1);
        ref_q.delete();
        ref_q.push_back(32'h0);
        ref_fault = 2'd0;
    endtask

    task automatic test_add();
        fresh_stack();
        do_cmd(3'd1, 32'd5);
        do_cmd(3'd1, 32'd7);
        do_cmd(3'd2, 32'd0);
        expect_const("add_top", stk_top, 32'd12);
    endtask

    task automatic test_sub();
        // SUB computes next minus top.
        fresh_stack();
        do_cmd(3'd1, 32'd3);
        do_cmd(3'd1, 32'd10);
        do_cmd(3'd3, 32'd0);
        expect_const("sub_3_minus_10", stk_top, 32'hFFFF_FFF9);
        fresh_stack();
        do_cmd(3'd1, 32'd10);
        do_cmd(3'd1, 32'd3);
        do_cmd(3'd3, 32'd0);
        expect_const("sub_10_minus_3", stk_top, 32'h0000_0007);
    endtask

    task automatic test_swap();
        fresh_stack();
        do_cmd(3'd1, 32'd1);
        do_cmd(3'd1, 32'd2);
        do_cmd(3'd7, 32'd0);
        expect_const("swap_top", stk_top, 32'd1);
        expect_const("swap_next", stk_next, 32'd2);
        expect_const("swap_count", 32'(stk_count), 32'd3);
    endtask

    task automatic test_underflow();
        fresh_stack();
        do_cmd(3'd2, 32'd0);
        expect_const("underflow_fault", 32'(fault), 32'd1);
        do_cmd(3'd6, 32'd0);
        expect_const("drop_single_fault", 32'(fault), 32'd1);
        expect_const("drop_single_top", stk_top, 32'd0);
    endtask

    task automatic test_mul();
        apply_reset();
        fresh_stack();
        do_cmd(3'd1, 32'h0001_0000);
        do_cmd(3'd1, 32'h0001_0000);
        do_cmd(3'd4, 32'd0);
        if (MUL_ON) expect_const("mul_top", stk_top, 32'h0);
        else        expect_const("mul_illegal", 32'(fault), 32'd3);
    endtask

    task automatic test_stk_error();
        apply_reset();
        fresh_stack();
        err_inject = 1'b1;
        @(negedge clock);
        err_inject = 1'b0;
        set_fault(2'd2);
        expect_const("stk_error_fault", 32'(fault), 32'd2);
        do_cmd(3'd2, 32'd0);
        expect_const("fault_sticky", 32'(fault), 32'd2);
    endtask

    task automatic test_overflow();
        apply_reset();
        fresh_stack();
        for (int i = 0; i < 63; i++) do_cmd(3'd1, $urandom);
        expect_const("full_count", 32'(stk_count), 32'd0);
        do_cmd(3'd5, 32'd0);
        expect_const("overflow_fault", 32'(fault), 32'd2);
        do_cmd(3'd6, 32'd0);
    endtask

    task automatic test_reset_mid_swap();
        fresh_stack();
        do_cmd(3'd1, 32'd1);
        do_cmd(3'd1, 32'd2);
        cmd_valid = 1'b1;
        cmd_op    = 3'd7;
        @(negedge clock);
        cmd_valid = 1'b0;
        expect_const("swap_pop_seen", 32'(stk_pop), 32'd1);
        @(negedge clock);
        expect_const("swap_write_seen", {stk_value[30:0], stk_write}, {31'd2, 1'b1});
        #1 reset = 1'b1;
        #1;
        expect_const("abort_outputs", {26'h0, stk_push, stk_pop, stk_write, done, cmd_ready, 1'b0}, 32'h0);
        expect_const("abort_fault", 32'(fault), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        expect_const("ready_after_abort", 32'(cmd_ready), 32'd1);
        ref_q.delete();
        ref_q.push_back(32'h0);
        ref_q.push_back(32'd1);
        ref_fault = 2'd0;
        check_stack("abandoned_swap");
        do_cmd(3'd2, 32'd0);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [31:0] v;
        apply_reset();
        fresh_stack();
        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 7));
            if (ref_q.size() < 3 && $urandom_range(0, 1) == 1) op = 3'd1;
            v = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
            do_cmd(op, v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_value = 32'h0;
        #1;
        test_reset();
        test_add();
        test_sub();
        test_swap();
        test_underflow();
        test_mul();
        test_stk_error();
        test_overflow();
        test_reset_mid_swap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
